// File: rtl/branch_commit_unit.sv
// Commit-side branch predictor update producer: buffers resolved branches in a
// small FIFO, drains one update per cycle, and raises a one-cycle redirect on mispredict.
module branch_commit_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int PTR_W      = 2
) (
   input  logic                  clk,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  commit_en,
   input  logic [ADDR_WIDTH-1:0] commit_pc,
   input  logic                  commit_pred,
   input  logic                  commit_taken,
   input  logic [ADDR_WIDTH-1:0] commit_target,
   output logic                  commit_ready,
   output logic                  pred_upd_en,
   output logic [ADDR_WIDTH-1:0] pred_upd_pc,
   output logic                  pred_upd_res,
   output logic                  flush_out,
   output logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic [31:0]           br_cnt,
   output logic [31:0]           mis_cnt
);

   typedef enum logic {S_RUN, S_FLUSH} state_t;

   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

   state_t                  state_q, state_d;
   logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]          count_q, count_d;
   logic [31:0]             br_cnt_q, mis_cnt_q;
   logic [ADDR_WIDTH-1:0]   redirect_q;
   logic [ADDR_WIDTH-1:0]   pc_mem_q  [DEPTH];
   logic                    res_mem_q [DEPTH];

   logic                    full, accept, push, pop, mispredict, not_empty;
   logic [ADDR_WIDTH-1:0]   correct_pc;

   assign full         = (count_q == DEPTH_C);
   assign not_empty    = (count_q != '0);
   assign commit_ready = rdy_in && !full && (state_q == S_RUN);
   assign accept       = commit_en && commit_ready;
   assign push         = accept;
   assign pop          = pred_upd_en;
   assign mispredict   = accept && (commit_pred != commit_taken);
   assign correct_pc   = commit_taken ? commit_target : commit_pc + ADDR_WIDTH'(4);

   // Head is gated so stale storage never leaks out while the queue is empty.
   assign pred_upd_en  = rdy_in && not_empty;
   assign pred_upd_pc  = not_empty ? pc_mem_q[rd_ptr_q]  : '0;
   assign pred_upd_res = not_empty ? res_mem_q[rd_ptr_q] : 1'b0;

   assign flush_out    = (state_q == S_FLUSH);
   assign redirect_pc  = redirect_q;
   assign br_cnt       = br_cnt_q;
   assign mis_cnt      = mis_cnt_q;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      if (rdy_in) begin
         case (state_q)
            S_RUN:   if (mispredict) state_d = S_FLUSH;
            S_FLUSH: state_d = S_RUN;
            default: state_d = S_RUN;
         endcase
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_in) begin
         state_q    <= S_RUN;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         br_cnt_q   <= '0;
         mis_cnt_q  <= '0;
         redirect_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (accept) br_cnt_q <= br_cnt_q + 32'd1;
         if (mispredict) begin
            mis_cnt_q  <= mis_cnt_q + 32'd1;
            redirect_q <= correct_pc;
         end
      end
   end

   // Storage has no reset; validity is tracked solely by the pointers and count.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
         if (push && (wr_ptr_q == PTR_W'(gi))) begin
            pc_mem_q[gi]  <= commit_pc;
            res_mem_q[gi] <= commit_taken;
         end
      end
   end

endmodule
